// File: rtl/sipo_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sipo_load_ctrl_pkg
// Shared definitions for the X-operand SIPO load controller and its counter:
//   - default geometry of the SIPO bank (component width, PE count, depth)
//   - controller state encoding
//   - index-width helper that never returns a zero width
// -----------------------------------------------------------------------------
package sipo_load_ctrl_pkg;

   // Default bank geometry
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_PE_NUM     = 256;
   localparam int DEF_REG_DEPTH  = 32;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_KEEP = 2'd2
   } ld_state_e;

   // Index width for a counter over n entries; a single-entry counter still
   // gets one bit so that no vector collapses to zero width.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sipo_load_ctrl_ld_counter.sv
// -----------------------------------------------------------------------------
// ld_counter
// Two-level word/PE counter used to sequence loads into a bank of shift
// registers. The inner (word) counter runs 0..REG_DEPTH-1; each time it wraps,
// the outer (PE) counter advances. After the very last word of the last PE
// both counters return to zero on their own.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr_i     in   synchronous clear of both counters (wins over inc_i)
//   inc_i     in   advance by one word
//   pe_cnt_o  out  current PE index
//   tc_o      out  terminal count: current word is the last word of the last PE
// -----------------------------------------------------------------------------
module ld_counter
   import sipo_load_ctrl_pkg::*;
#(
   parameter int PE_NUM    = DEF_PE_NUM,
   parameter int REG_DEPTH = DEF_REG_DEPTH,
   parameter int PE_AW     = idx_width(PE_NUM),
   parameter int RD_AW     = idx_width(REG_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [PE_AW-1:0] pe_cnt_o,
   output logic             tc_o
);

   logic [RD_AW-1:0] reg_cnt_q, reg_cnt_d;
   logic [PE_AW-1:0] pe_cnt_q,  pe_cnt_d;
   logic             reg_last;
   logic             pe_last;

   assign reg_last = (reg_cnt_q == RD_AW'(REG_DEPTH - 1));
   assign pe_last  = (pe_cnt_q  == PE_AW'(PE_NUM - 1));

   always_comb begin
      reg_cnt_d = reg_cnt_q;
      pe_cnt_d  = pe_cnt_q;
      if (clr_i) begin
         reg_cnt_d = '0;
         pe_cnt_d  = '0;
      end else if (inc_i) begin
         if (reg_last) begin
            reg_cnt_d = '0;
            // Explicit wrap so non-power-of-two PE counts also return to 0
            pe_cnt_d  = pe_last ? '0 : pe_cnt_q + PE_AW'(1);
         end else begin
            reg_cnt_d = reg_cnt_q + RD_AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_cnt_q <= '0;
         pe_cnt_q  <= '0;
      end else begin
         reg_cnt_q <= reg_cnt_d;
         pe_cnt_q  <= pe_cnt_d;
      end
   end

   assign pe_cnt_o = pe_cnt_q;
   assign tc_o     = reg_last & pe_last;

endmodule

// File: rtl/sipo_load_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_load_ctrl
// Load controller for the X-operand serial-in/parallel-out bank feeding the PE
// array. Accepts complex words over a valid/ready handshake and issues each
// accepted word, one cycle later, to exactly one PE shift register. REG_DEPTH
// words go to each PE in turn; after the final word of the last PE the bank is
// frozen (KEEP) until the array releases it or a new batch is started.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start_i      in   begin a batch (honoured in IDLE and KEEP)
//   release_i    in   array done with the bank, back to IDLE (KEEP only)
//   s_valid_i    in   input word valid
//   s_data_i     in   input word {real, imag}, 2*DATA_WIDTH bits
//   s_ready_o    out  word accepted this cycle if s_valid_i is high
//   ce_o         out  shift enable for the PE selected by pe_sel_o
//   pe_sel_o     out  PE index receiving srl_din_o
//   srl_din_o    out  word for the selected shift register, 0 when ce_o=0
//   busy_o       out  loading
//   loaded_o     out  bank contents valid (KEEP)
//   done_o       out  one-cycle pulse together with the final ce_o of a batch
// -----------------------------------------------------------------------------
module sipo_load_ctrl
   import sipo_load_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PE_NUM     = DEF_PE_NUM,
   parameter int REG_DEPTH  = DEF_REG_DEPTH,
   parameter int PE_AW      = idx_width(PE_NUM),
   parameter int RD_AW      = idx_width(REG_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   input  logic                    release_i,
   input  logic                    s_valid_i,
   input  logic [2*DATA_WIDTH-1:0] s_data_i,
   output logic                    s_ready_o,
   output logic                    ce_o,
   output logic [PE_AW-1:0]        pe_sel_o,
   output logic [2*DATA_WIDTH-1:0] srl_din_o,
   output logic                    busy_o,
   output logic                    loaded_o,
   output logic                    done_o
);

   ld_state_e               state_q, state_d;
   logic                    s_ready_q;
   logic                    busy_q;
   logic                    loaded_q;
   logic                    ce_q;
   logic [PE_AW-1:0]        pe_sel_q;
   logic [2*DATA_WIDTH-1:0] srl_din_q;
   logic                    done_q;

   logic                    accept;
   logic                    cnt_clr;
   logic                    cnt_tc;
   logic [PE_AW-1:0]        pe_cnt;

   // s_ready_q is only ever high in LOAD, so accept needs no state term
   assign accept = s_valid_i & s_ready_q;

   ld_counter #(
      .PE_NUM    (PE_NUM),
      .REG_DEPTH (REG_DEPTH),
      .PE_AW     (PE_AW),
      .RD_AW     (RD_AW)
   ) u_ld_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (cnt_clr),
      .inc_i    (accept),
      .pe_cnt_o (pe_cnt),
      .tc_o     (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_LOAD;
               cnt_clr = 1'b1;
            end
         end
         ST_LOAD: begin
            // start is ignored here; the counter wraps itself on the last word
            if (accept && cnt_tc) begin
               state_d = ST_KEEP;
            end
         end
         ST_KEEP: begin
            // A reload request wins over a simultaneous release
            if (start_i) begin
               state_d = ST_LOAD;
               cnt_clr = 1'b1;
            end else if (release_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
         end
      endcase
   end

   // State, decoded status flags and the registered issue stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         loaded_q  <= 1'b0;
         ce_q      <= 1'b0;
         pe_sel_q  <= '0;
         srl_din_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d == ST_LOAD);
         busy_q    <= (state_d == ST_LOAD);
         loaded_q  <= (state_d == ST_KEEP);

         ce_q      <= accept;
         done_q    <= accept & cnt_tc;
         srl_din_q <= accept ? s_data_i : '0;
         if (accept) begin
            pe_sel_q <= pe_cnt;
         end
      end
   end

   assign s_ready_o = s_ready_q;
   assign busy_o    = busy_q;
   assign loaded_o  = loaded_q;
   assign ce_o      = ce_q;
   assign pe_sel_o  = pe_sel_q;
   assign srl_din_o = srl_din_q;
   assign done_o    = done_q;

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_load_ctrl
// Directed sequence with randomized data and control, checked against a
// word-count model of the loader (4 PEs x 4 words, 16-bit components).
// -----------------------------------------------------------------------------
module tb_sipo_load_ctrl;

   localparam int DW    = 16;
   localparam int PN    = 4;
   localparam int RD    = 4;
   localparam int TOTAL = PN * RD;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          rel;
   logic          s_valid;
   logic [2*DW-1:0] s_data;
   logic          s_ready;
   logic          ce;
   logic [1:0]    pe_sel;
   logic [2*DW-1:0] srl_din;
   logic          busy;
   logic          loaded;
   logic          done;

   int compared   = 0;
   int mismatched = 0;

   // Model: 0 = idle, 1 = loading, 2 = bank held; m_cnt = words taken so far
   int m_state;
   int m_cnt;
   int ce_seen;
   int done_seen;

   always #5 clk = ~clk;

   sipo_load_ctrl #(
      .DATA_WIDTH (DW),
      .PE_NUM     (PN),
      .REG_DEPTH  (RD),
      .PE_AW      (2),
      .RD_AW      (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start),
      .release_i (rel),
      .s_valid_i (s_valid),
      .s_data_i  (s_data),
      .s_ready_o (s_ready),
      .ce_o      (ce),
      .pe_sel_o  (pe_sel),
      .srl_din_o (srl_din),
      .busy_o    (busy),
      .loaded_o  (loaded),
      .done_o    (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " s_ready"}, 32'(s_ready), 32'd0);
      chk({tag, " ce"},      32'(ce),      32'd0);
      chk({tag, " pe_sel"},  32'(pe_sel),  32'd0);
      chk({tag, " srl_din"}, srl_din,      32'd0);
      chk({tag, " busy"},    32'(busy),    32'd0);
      chk({tag, " loaded"},  32'(loaded),  32'd0);
      chk({tag, " done"},    32'(done),    32'd0);
   endtask

   // One clock: apply inputs, step the model, check outputs #1 after the edge
   task automatic cyc(input logic sv, input logic [31:0] d, input logic st, input logic rl);
      logic        acc;
      logic        e_done;
      logic [31:0] e_din;
      int          e_pe;
      s_valid = sv;
      s_data  = d;
      start   = st;
      rel     = rl;
      acc    = (m_state == 1) && sv;
      e_pe   = m_cnt / RD;
      e_din  = acc ? d : 32'd0;
      e_done = acc && (m_cnt == TOTAL - 1);
      case (m_state)
         0: if (st) begin m_state = 1; m_cnt = 0; end
         1: if (acc) begin
               m_cnt++;
               if (m_cnt == TOTAL) begin m_state = 2; m_cnt = 0; end
            end
         default: if (st) begin m_state = 1; m_cnt = 0; end
                  else if (rl) m_state = 0;
      endcase
      @(posedge clk);
      #1;
      ce_seen   += int'(ce);
      done_seen += int'(done);
      chk("s_ready", 32'(s_ready), 32'(m_state == 1));
      chk("busy",    32'(busy),    32'(m_state == 1));
      chk("loaded",  32'(loaded),  32'(m_state == 2));
      chk("ce",      32'(ce),      32'(acc));
      chk("done",    32'(done),    32'(e_done));
      chk("srl_din", srl_din,      e_din);
      if (acc) chk("pe_sel", 32'(pe_sel), 32'(e_pe));
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      rel     = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_state = 0;
      m_cnt   = 0;
      ce_seen = 0;
      done_seen = 0;

      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset in the middle of a batch, after five accepts
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      m_state = 0;
      m_cnt   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full batch of consecutive words 1..16
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      ce_seen = 0; done_seen = 0;
      for (int i = 0; i < TOTAL; i++) cyc(1'b1, 32'(i + 1), 1'b0, 1'b0);
      chk("full ce count",   32'(ce_seen),   32'(TOTAL));
      chk("full done count", 32'(done_seen), 32'd1);

      // Bank held: valid data offered but never taken; then release
      for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
      chk("keep ce count", 32'(ce_seen), 32'(TOTAL));
      cyc(1'b0, 32'd0, 1'b0, 1'b1);
      cyc(1'b0, 32'd0, 1'b0, 1'b0);

      // Alternating valid: gaps must neither advance nor write
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      ce_seen = 0; done_seen = 0;
      for (int i = 0; i < 2 * TOTAL; i++) cyc(1'((i % 2) == 0), $urandom, 1'b0, 1'b0);
      chk("stall ce count",   32'(ce_seen),   32'(TOTAL));
      chk("stall done count", 32'(done_seen), 32'd1);

      // Reload: start and release together in KEEP, start wins
      cyc(1'b0, 32'd0, 1'b1, 1'b1);
      ce_seen = 0; done_seen = 0;
      // start pulsed alongside word 7 must be ignored
      for (int i = 0; i < TOTAL; i++) cyc(1'b1, $urandom, 1'(i == 6), 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
      chk("reload ce count",   32'(ce_seen),   32'(TOTAL));
      chk("reload done count", 32'(done_seen), 32'd1);

      // Random control and data
      for (int i = 0; i < 300; i++)
         cyc(1'($urandom_range(0, 3) != 0), $urandom,
             1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
